num_splitter_seq: RTL and testbench

NUM_SPLITTER_SEQ -- requirements
Module: num_splitter_seq

---
 rtl/num_splitter_seq_if.sv | 23 ++
 rtl/num_splitter_seq.sv | 133 +++++++++++++
 tb/tb_num_splitter_seq.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/num_splitter_seq_if.sv
// Handshake and result bundle between a requester and the binary-to-BCD splitter.
// The requester drives the operand and start; the splitter returns status and digits.
interface num_splitter_seq_if #(
  parameter int IN_W   = 8,
  parameter int DIGITS = 3
);
  logic [IN_W-1:0]     numero;
  logic                start;
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] digitos;
  logic                ovf;

  modport master (
    output numero, start,
    input  busy, done, digitos, ovf
  );

  modport slave (
    input  numero, start,
    output busy, done, digitos, ovf
  );
endinterface

// File: rtl/num_splitter_seq.sv
// Sequential binary-to-BCD splitter using one double-dabble step per clock.
// Results are loaded on the edge that leaves DONE, so done pulses in the first IDLE cycle.
module num_splitter_seq #(
  parameter int IN_W   = 8,
  parameter int DIGITS = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  num_splitter_seq_if.slave  bus
);

  function automatic int dec_digits(input int w);
    int v;
    int n;
    v = (1 << w) - 1;
    n = 0;
    for (int k = 0; k < 6; k++) begin
      if (v > 0) begin
        n++;
        v = v / 10;
      end
    end
    return n;
  endfunction

  // Scratch is sized for the full input range so overflow can be detected,
  // and never narrower than the output so the low digits always exist.
  localparam int SD    = dec_digits(IN_W);
  localparam int SW    = (SD > DIGITS) ? SD : DIGITS;
  localparam int CNT_W = $clog2(IN_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IN_W-1:0]     op_q, op_d;
  logic [4*SW-1:0]     scr_q, scr_d;
  logic [4*SW-1:0]     adj;
  logic [4*DIGITS-1:0] dig_q, dig_d;
  logic                ovf_q, ovf_d;
  logic                done_q, done_d;
  logic                hi_nz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = SHIFT;
      SHIFT:   if (cnt_q == CNT_W'(1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_q != IDLE);
  end

  assign bus.done    = done_q;
  assign bus.digitos = dig_q;
  assign bus.ovf     = ovf_q;

  always_comb begin
    logic [3:0] d;
    adj = '0;
    for (int i = 0; i < SW; i++) begin
      d = scr_q[4*i +: 4];
      adj[4*i +: 4] = (d >= 4'd5) ? d + 4'd3 : d;
    end
  end

  always_comb begin
    hi_nz = 1'b0;
    for (int i = 0; i < SW; i++) begin
      if (i >= DIGITS) hi_nz = hi_nz | (|scr_q[4*i +: 4]);
    end
  end

  always_comb begin
    op_d   = op_q;
    scr_d  = scr_q;
    cnt_d  = cnt_q;
    dig_d  = dig_q;
    ovf_d  = ovf_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d  = bus.numero;
          scr_d = '0;
          cnt_d = CNT_W'(IN_W);
        end
      end
      SHIFT: begin
        scr_d = {adj[4*SW-2:0], op_q[IN_W-1]};
        op_d  = {op_q[IN_W-2:0], 1'b0};
        cnt_d = cnt_q - CNT_W'(1);
      end
      DONE: begin
        dig_d  = scr_q[4*DIGITS-1:0];
        ovf_d  = hi_nz;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      op_q   <= '0;
      scr_q  <= '0;
      dig_q  <= '0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      op_q   <= op_d;
      scr_q  <= scr_d;
      dig_q  <= dig_d;
      ovf_q  <= ovf_d;
      done_q <= done_d;
    end
  end

endmodule

// File: tb/tb_num_splitter_seq.sv
// Directed and random bench for the BCD splitter; two instances share stimulus,
// one with three output digits and one with two so the overflow path is exercised.
module tb_num_splitter_seq;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  num_splitter_seq_if #(.IN_W(8), .DIGITS(3)) b3 ();
  num_splitter_seq_if #(.IN_W(8), .DIGITS(2)) b2 ();

  assign b2.numero = b3.numero;
  assign b2.start  = b3.start;

  num_splitter_seq #(.IN_W(8), .DIGITS(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));
  num_splitter_seq #(.IN_W(8), .DIGITS(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pow10(input int n);
    int p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  // Reference: decimal digits of (v mod 10^d), packed four bits per digit.
  function automatic logic [31:0] bcd_of(input int v, input int d);
    logic [31:0] b = '0;
    int r = v % pow10(d);
    for (int i = 0; i < d; i++) b[4*i +: 4] = 4'((r / pow10(i)) % 10);
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_result(input int v);
    chk("dig3", 32'(b3.digitos), bcd_of(v, 3));
    chk("ovf3", 32'(b3.ovf), 32'(v >= 1000));
    chk("dig2", 32'(b2.digitos), bcd_of(v, 2));
    chk("ovf2", 32'(b2.ovf), 32'(v >= 100));
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_busy"}, 32'(b3.busy), 32'd0);
    chk({tag, "_done"}, 32'(b3.done), 32'd0);
    chk({tag, "_dig3"}, 32'(b3.digitos), 32'd0);
    chk({tag, "_ovf3"}, 32'(b3.ovf), 32'd0);
    chk({tag, "_dig2"}, 32'(b2.digitos), 32'd0);
    chk({tag, "_ovf2"}, 32'(b2.ovf), 32'd0);
  endtask

  // Pulse start with v, scramble numero afterwards, check fixed latency and result.
  task automatic convert(input int v);
    b3.numero = 8'(v);
    b3.start  = 1'b1;
    tick();
    b3.start  = 1'b0;
    b3.numero = 8'($urandom_range(0, 255));
    for (int k = 0; k <= 8; k++) begin
      chk("busy_run", 32'(b3.busy), 32'd1);
      chk("done_early", 32'(b3.done), 32'd0);
      tick();
    end
    chk("done_pulse", 32'(b3.done), 32'd1);
    chk("done_pulse2", 32'(b2.done), 32'd1);
    chk("busy_after", 32'(b3.busy), 32'd0);
    check_result(v);
    tick();
    chk("done_one", 32'(b3.done), 32'd0);
    check_result(v);
  endtask

  initial begin
    int v;
    rst_n     = 1'b1;
    b3.start  = 1'b0;
    b3.numero = '0;
    #2 rst_n = 1'b0;
    #1 check_idle_zero("rst0");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_idle_zero("post_rst");

    convert(45);
    convert(255);
    convert(0);
    convert(199);
    convert(99);
    convert(100);
    convert(1);

    for (int n = 0; n < 20; n++) begin
      v = int'($urandom_range(0, 255));
      convert(v);
    end

    // Second start during a conversion is ignored; numero change has no effect.
    b3.numero = 8'd67;
    b3.start  = 1'b1;
    tick();
    b3.start  = 1'b0;
    b3.numero = 8'd12;
    tick();
    tick();
    b3.start  = 1'b1;
    tick();
    b3.start  = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    chk("ign_done", 32'(b3.done), 32'd1);
    check_result(67);
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("ign_nodone", 32'(b3.done), 32'd0);
      chk("ign_busy", 32'(b3.busy), 32'd0);
      chk("ign_hold", 32'(b3.digitos), bcd_of(67, 3));
    end

    // Start held high: back-to-back conversions every 10 cycles.
    b3.numero = 8'd38;
    b3.start  = 1'b1;
    tick();
    for (int c = 1; c <= 30; c++) begin
      tick();
      chk("held_done", 32'(b3.done), 32'((c % 10) == 9));
      if ((c % 10) == 9) check_result(38);
    end
    b3.start = 1'b0;
    for (int k = 0; k < 12; k++) tick();
    chk("held_drain", 32'(b3.busy), 32'd0);

    // Reset mid-conversion: asynchronous clear, no done, fresh conversion afterwards.
    convert(45);
    b3.numero = 8'd80;
    b3.start  = 1'b1;
    tick();
    b3.start  = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("pre_abort_busy", 32'(b3.busy), 32'd1);
    rst_n = 1'b0;
    #1 check_idle_zero("abort");
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("abort_nodone", 32'(b3.done), 32'd0);
    end
    rst_n = 1'b1;
    tick();
    check_idle_zero("abort_rel");
    convert(80);

    // Start held across reset release: conversion begins at first edge with rst_n=1.
    rst_n     = 1'b0;
    b3.numero = 8'd123;
    b3.start  = 1'b1;
    tick();
    tick();
    chk("rst_hold_busy", 32'(b3.busy), 32'd0);
    rst_n = 1'b1;
    tick();
    b3.start = 1'b0;
    chk("rel_busy", 32'(b3.busy), 32'd1);
    for (int k = 0; k < 9; k++) tick();
    chk("rel_done", 32'(b3.done), 32'd1);
    check_result(123);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
